fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 32 +++
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: icache request/response, EX redirect inputs, and IF/ID outputs.
// master = the fetch stage, slave = the icache/hazard/decode side that drives it.
interface fetch_stage_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] imemaddr;
    logic              imemREN;
    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              stall;
    logic              halt;
    logic [1:0]        pc_src;
    logic [WORD_W-1:0] ex_npc;
    logic [15:0]       ex_imm16;
    logic [25:0]       ex_jaddr;
    logic [WORD_W-1:0] ex_rsdata;
    logic              flush;
    logic [WORD_W-1:0] ifid_instr;
    logic [WORD_W-1:0] ifid_npc;
    logic              ifid_valid;
    logic              fetch_halted;

    modport master (
        output imemaddr, imemREN, flush, ifid_instr, ifid_npc, ifid_valid, fetch_halted,
        input  ihit, imemload, stall, halt, pc_src, ex_npc, ex_imm16, ex_jaddr, ex_rsdata
    );

    modport slave (
        input  imemaddr, imemREN, flush, ifid_instr, ifid_npc, ifid_valid, fetch_halted,
        output ihit, imemload, stall, halt, pc_src, ex_npc, ex_imm16, ex_jaddr, ex_rsdata
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues icache reads, applies EX redirects,
// and holds the IF/ID pipeline register. Fetch stops on HALT until a redirect restarts it.
module fetch_stage #(
    parameter int                WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = '0
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_stage_if.master fif
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [WORD_W-1:0] ifid_npc_q, ifid_npc_d;
    logic              ifid_valid_q, ifid_valid_d;
    logic              redirect;
    logic [WORD_W-1:0] pc_plus4;
    logic [WORD_W-1:0] target;

    // All target arithmetic wraps modulo 2^32; jr targets are taken verbatim.
    function automatic logic [WORD_W-1:0] redirect_target(
        input logic [1:0]        sel,
        input logic [WORD_W-1:0] npc,
        input logic [15:0]       imm16,
        input logic [25:0]       jaddr,
        input logic [WORD_W-1:0] rsdata
    );
        logic signed [WORD_W-1:0] br_off;
        br_off = {{14{imm16[15]}}, imm16, 2'b00};
        case (sel)
            2'b01:   return npc + $unsigned(br_off);
            2'b10:   return {npc[31:28], jaddr, 2'b00};
            2'b11:   return rsdata;
            default: return npc;
        endcase
    endfunction

    assign redirect = (fif.pc_src != 2'b00);
    assign pc_plus4 = pc_q + 32'd4;
    assign target   = redirect_target(fif.pc_src, fif.ex_npc, fif.ex_imm16,
                                      fif.ex_jaddr, fif.ex_rsdata);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_npc_d   = ifid_npc_q;
        ifid_valid_d = ifid_valid_q;
        if (redirect) begin
            // Redirect wins over everything, including HALTED and an outstanding miss.
            pc_d         = target;
            ifid_valid_d = 1'b0;
            ifid_instr_d = '0;
            state_d      = RUN;
        end else if (fif.stall) begin
            state_d = state_q;
        end else if (state_q == RUN) begin
            if (fif.halt && ifid_valid_q) begin
                state_d      = HALTED;
                ifid_valid_d = 1'b0;
            end else if (fif.ihit) begin
                pc_d         = pc_plus4;
                ifid_instr_d = fif.imemload;
                ifid_npc_d   = pc_plus4;
                ifid_valid_d = 1'b1;
            end else begin
                ifid_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= RUN;
            pc_q         <= PC_INIT;
            ifid_instr_q <= '0;
            ifid_npc_q   <= '0;
            ifid_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_npc_q   <= ifid_npc_d;
            ifid_valid_q <= ifid_valid_d;
        end
    end

    assign fif.imemaddr     = pc_q;
    assign fif.imemREN      = (state_q == RUN) && !RST;
    assign fif.flush        = redirect && !RST;
    assign fif.fetch_halted = (state_q == HALTED);
    assign fif.ifid_instr   = ifid_instr_q;
    assign fif.ifid_npc     = ifid_npc_q;
    assign fif.ifid_valid   = ifid_valid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a cycle-by-cycle vector table plus an
// asynchronous reset asserted in the middle of a stalled miss.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if #(.WORD_W(32)) fif ();

    fetch_stage #(.WORD_W(32), .PC_INIT(32'h0000_0000)) dut (
        .CLK(clk),
        .RST(rst),
        .fif(fif)
    );

    typedef struct {
        logic        ihit;
        logic [31:0] load;
        logic        stall;
        logic        halt;
        logic [1:0]  src;
        logic [31:0] npc;
        logic [15:0] imm;
        logic [25:0] jaddr;
        logic [31:0] rs;
        logic [31:0] e_addr;
        logic        e_ren;
        logic        e_flush;
        logic        e_vld;
        logic [31:0] e_instr;
        logic [31:0] e_npc;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic ihit, input logic [31:0] load, input logic stall,
                       input logic halt, input logic [1:0] src, input logic [31:0] npc,
                       input logic [15:0] imm, input logic [25:0] jaddr, input logic [31:0] rs,
                       input logic [31:0] e_addr, input logic e_ren, input logic e_flush,
                       input logic e_vld, input logic [31:0] e_instr, input logic [31:0] e_npc,
                       input logic e_halt);
        vec_t v;
        v.ihit = ihit; v.load = load; v.stall = stall; v.halt = halt; v.src = src;
        v.npc = npc; v.imm = imm; v.jaddr = jaddr; v.rs = rs;
        v.e_addr = e_addr; v.e_ren = e_ren; v.e_flush = e_flush;
        v.e_vld = e_vld; v.e_instr = e_instr; v.e_npc = e_npc; v.e_halt = e_halt;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        fif.ihit      = v.ihit;
        fif.imemload  = v.load;
        fif.stall     = v.stall;
        fif.halt      = v.halt;
        fif.pc_src    = v.src;
        fif.ex_npc    = v.npc;
        fif.ex_imm16  = v.imm;
        fif.ex_jaddr  = v.jaddr;
        fif.ex_rsdata = v.rs;
    endtask

    initial begin
        fif.ihit = 1'b0; fif.imemload = '0; fif.stall = 1'b0; fif.halt = 1'b0;
        fif.pc_src = 2'b01; fif.ex_npc = 32'h100; fif.ex_imm16 = '0;
        fif.ex_jaddr = '0; fif.ex_rsdata = '0;

        //   ihit load          st h src npc           imm       jaddr      rs            | addr         ren fl | vld instr         npc           hlt
        add(1, 32'hA000_0000, 0, 0, 0, 0,            0,        0,         0,            32'h0000_0000, 1, 0, 1, 32'hA000_0000, 32'h0000_0004, 0);
        add(1, 32'hA000_0001, 0, 0, 0, 0,            0,        0,         0,            32'h0000_0004, 1, 0, 1, 32'hA000_0001, 32'h0000_0008, 0);
        add(1, 32'hA000_0002, 0, 0, 0, 0,            0,        0,         0,            32'h0000_0008, 1, 0, 1, 32'hA000_0002, 32'h0000_000C, 0);
        add(1, 32'hA000_0003, 0, 0, 0, 0,            0,        0,         0,            32'h0000_000C, 1, 0, 1, 32'hA000_0003, 32'h0000_0010, 0);
        for (int i = 0; i < 3; i++)
            add(0, 32'hDEAD_BEEF, 0, 0, 0, 0,        0,        0,         0,            32'h0000_0010, 1, 0, 0, 32'hA000_0003, 32'h0000_0010, 0);
        add(1, 32'hA000_0004, 0, 0, 0, 0,            0,        0,         0,            32'h0000_0010, 1, 0, 1, 32'hA000_0004, 32'h0000_0014, 0);
        add(1, 32'hA000_0005, 0, 0, 1, 32'h20,       16'hFFFE, 0,         0,            32'h0000_0014, 1, 1, 0, 32'h0,         32'h0000_0014, 0);
        add(0, 32'h0,         0, 0, 3, 0,            0,        0,         32'h400,      32'h0000_0018, 1, 1, 0, 32'h0,         32'h0000_0014, 0);
        add(0, 32'h0,         0, 0, 2, 32'h9000_0000, 0,       26'h10,    0,            32'h0000_0400, 1, 1, 0, 32'h0,         32'h0000_0014, 0);
        add(1, 32'hB000_0000, 0, 0, 0, 0,            0,        0,         0,            32'h9000_0040, 1, 0, 1, 32'hB000_0000, 32'h9000_0044, 0);
        add(1, 32'hB000_0001, 0, 1, 0, 0,            0,        0,         0,            32'h9000_0044, 1, 0, 0, 32'hB000_0000, 32'h9000_0044, 1);
        add(1, 32'hB000_0002, 0, 0, 0, 0,            0,        0,         0,            32'h9000_0044, 0, 0, 0, 32'hB000_0000, 32'h9000_0044, 1);
        add(0, 32'h0,         0, 0, 2, 32'h1000_0000, 0,       26'h20,    0,            32'h9000_0044, 0, 1, 0, 32'h0,         32'h9000_0044, 0);
        add(1, 32'hC000_0000, 0, 0, 0, 0,            0,        0,         0,            32'h1000_0080, 1, 0, 1, 32'hC000_0000, 32'h1000_0084, 0);
        add(1, 32'hC000_0001, 1, 1, 0, 0,            0,        0,         0,            32'h1000_0084, 1, 0, 1, 32'hC000_0000, 32'h1000_0084, 0);
        add(1, 32'hC000_0001, 1, 1, 0, 0,            0,        0,         0,            32'h1000_0084, 1, 0, 1, 32'hC000_0000, 32'h1000_0084, 0);
        add(0, 32'h0,         0, 0, 0, 0,            0,        0,         0,            32'h1000_0084, 1, 0, 0, 32'hC000_0000, 32'h1000_0084, 0);
        add(1, 32'hC000_0001, 0, 1, 0, 0,            0,        0,         0,            32'h1000_0084, 1, 0, 1, 32'hC000_0001, 32'h1000_0088, 0);
        add(1, 32'h0,         0, 0, 3, 0,            0,        0,         32'hFFFF_FFFC, 32'h1000_0088, 1, 1, 0, 32'h0,         32'h1000_0088, 0);
        add(1, 32'hD000_0000, 0, 0, 0, 0,            0,        0,         0,            32'hFFFF_FFFC, 1, 0, 1, 32'hD000_0000, 32'h0000_0000, 0);
        add(1, 32'hD000_0001, 0, 0, 0, 0,            0,        0,         0,            32'h0000_0000, 1, 0, 1, 32'hD000_0001, 32'h0000_0004, 0);

        // Reset state while RST is held, with a redirect request present.
        #3;
        chk("rst_addr",   fif.imemaddr,     32'h0);
        chk("rst_ren",    32'(fif.imemREN), 32'h0);
        chk("rst_flush",  32'(fif.flush),   32'h0);
        chk("rst_vld",    32'(fif.ifid_valid), 32'h0);
        chk("rst_instr",  fif.ifid_instr,   32'h0);
        chk("rst_npc",    fif.ifid_npc,     32'h0);
        chk("rst_halted", 32'(fif.fetch_halted), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        fif.pc_src = 2'b00;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            chk($sformatf("v%0d_addr", i),  fif.imemaddr,         vecs[i].e_addr);
            chk($sformatf("v%0d_ren", i),   32'(fif.imemREN),     32'(vecs[i].e_ren));
            chk($sformatf("v%0d_flush", i), 32'(fif.flush),       32'(vecs[i].e_flush));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_vld", i),   32'(fif.ifid_valid),  32'(vecs[i].e_vld));
            chk($sformatf("v%0d_instr", i), fif.ifid_instr,       vecs[i].e_instr);
            chk($sformatf("v%0d_npc", i),   fif.ifid_npc,         vecs[i].e_npc);
            chk($sformatf("v%0d_halt", i),  32'(fif.fetch_halted), 32'(vecs[i].e_halt));
        end

        // Stall a miss away from PC_INIT, then hit it with an asynchronous reset mid-cycle.
        @(negedge clk);
        fif.ihit = 1'b0; fif.stall = 1'b1; fif.halt = 1'b0; fif.pc_src = 2'b00;
        #2;
        rst = 1'b1;
        fif.pc_src = 2'b01;
        #1;
        chk("arst_addr",  fif.imemaddr,        32'h0);
        chk("arst_ren",   32'(fif.imemREN),    32'h0);
        chk("arst_flush", 32'(fif.flush),      32'h0);
        chk("arst_vld",   32'(fif.ifid_valid), 32'h0);
        chk("arst_instr", fif.ifid_instr,      32'h0);
        chk("arst_npc",   fif.ifid_npc,        32'h0);
        @(negedge clk);
        rst = 1'b0;
        fif.pc_src = 2'b00; fif.stall = 1'b0;
        fif.ihit = 1'b1; fif.imemload = 32'hE000_0000;
        #1;
        chk("rel_addr", fif.imemaddr,     32'h0);
        chk("rel_ren",  32'(fif.imemREN), 32'h1);
        @(posedge clk);
        #1;
        chk("rel_vld",   32'(fif.ifid_valid), 32'h1);
        chk("rel_instr", fif.ifid_instr,      32'hE000_0000);
        chk("rel_npc",   fif.ifid_npc,        32'h4);
        chk("rel_next",  fif.imemaddr,        32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
